stdp_update_seq: RTL

// Sequences the STDP weight-update phase of one neuron column. Shares one comp_edge case/probability

---
 rtl/stdp_update_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/stdp_update_seq.sv
// STDP weight-update sequencer for one neuron column: walks N_SYN synapses through
// read / evaluate / write-back, sharing one comp_edge datapath and one LFSR.
module stdp_update_seq #(
  parameter int N_SYN  = 16,
  parameter int W_BITS = 3,
  parameter int P_BITS = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [N_SYN-1:0]         x_edge_vec_i,
  input  logic                     y_edge_in_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     x_edge_o,
  output logic                     y_edge_o,
  input  logic [P_BITS-1:0]        prob_i,
  input  logic                     inc_i,
  input  logic [P_BITS-1:0]        rand_i,
  output logic                     rand_adv_o,
  output logic [$clog2(N_SYN)-1:0] w_addr_o,
  output logic                     w_rd_en_o,
  input  logic [W_BITS-1:0]        w_rd_data_i,
  output logic                     w_wr_en_o,
  output logic [W_BITS-1:0]        w_wr_data_o
);

  localparam int AW = $clog2(N_SYN);
  localparam logic [W_BITS-1:0] W_MAX = '1;
  localparam logic [AW-1:0]     IDX_LAST = AW'(N_SYN - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_EV, S_WR, S_DONE} state_t;

  state_t            state_q;
  logic [AW-1:0]     idx_q;
  logic [N_SYN-1:0]  snap_x_q;
  logic              snap_y_q;

  logic [AW-1:0]     idx_d;
  logic [W_BITS-1:0] new_w_d;
  logic              fire_d;
  logic              wr_d;

  // Evaluation datapath: only meaningful in EV, where w_rd_data_i is valid.
  always_comb begin
    idx_d   = idx_q + 1'b1;
    fire_d  = (rand_i < prob_i);
    new_w_d = w_rd_data_i;
    if (inc_i) begin
      if (w_rd_data_i != W_MAX) new_w_d = w_rd_data_i + 1'b1;
    end else begin
      if (w_rd_data_i != '0)    new_w_d = w_rd_data_i - 1'b1;
    end
    wr_d = fire_d && (new_w_d != w_rd_data_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      snap_x_q    <= '0;
      snap_y_q    <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      x_edge_o    <= 1'b0;
      y_edge_o    <= 1'b0;
      rand_adv_o  <= 1'b0;
      w_addr_o    <= '0;
      w_rd_en_o   <= 1'b0;
      w_wr_en_o   <= 1'b0;
      w_wr_data_o <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            // Snapshot feeds later synapses; synapse 0 takes the live inputs directly.
            snap_x_q  <= x_edge_vec_i;
            snap_y_q  <= y_edge_in_i;
            idx_q     <= '0;
            w_addr_o  <= '0;
            x_edge_o  <= x_edge_vec_i[0];
            y_edge_o  <= y_edge_in_i;
            w_rd_en_o <= 1'b1;
            busy_o    <= 1'b1;
            state_q   <= S_RD;
          end
        end
        S_RD: begin
          w_rd_en_o <= 1'b0;
          state_q   <= S_EV;
        end
        S_EV: begin
          w_wr_en_o   <= wr_d;
          w_wr_data_o <= new_w_d;
          rand_adv_o  <= 1'b1;
          state_q     <= S_WR;
        end
        S_WR: begin
          w_wr_en_o  <= 1'b0;
          rand_adv_o <= 1'b0;
          if (idx_q == IDX_LAST) begin
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q     <= idx_d;
            w_addr_o  <= idx_d;
            x_edge_o  <= snap_x_q[idx_d];
            y_edge_o  <= snap_y_q;
            w_rd_en_o <= 1'b1;
            state_q   <= S_RD;
          end
        end
        S_DONE: begin
          done_o  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
